color_handler: RTL and testbench
================================

// Module: color_handler
// PURPOSE
// - Colour/flash back end of the VGA input-decode path: holds character and background RGB
//   colours, stepping one 3-bit channel per decoded colour command, plus a blink strobe for
//   character flashing. Fed by input decode; outputs go to the pixel generator.
// PARAMETERS
// - CH_W        3          bits per colour channel (RGB word = 3*CH_W)
// - CHAR_INIT   9'h1FF     character colour after reset (white)
// - BK_INIT     9'h000     background colour after reset (black)
// - FLASH_DIV   25000000   clock cycles per flashClk half-period (0.5 s at 50 MHz); >=1
// PORTS
// - clock         in   1    single system clock, all state on rising edge
// - reset         in   1    asynchronous, active-low reset
// - enBkgrd       in   1    1 = colour commands edit background, 0 = edit character
// - outColor      in   3    one-hot-ish command: bit0 R step, bit1 G step, bit2 B step
// - enFlash       in   1    1 = character blinks, 0 = steady
// - charRgbDepth  out  9    character colour {R[8:6],G[5:3],B[2:0]}
// - bkRgbDepth    out  9    background colour, same layout
// - flashClk      out  1    character visibility strobe (1 = draw character)
// BEHAVIOUR
// - Reset (reset==0, async): charRgbDepth=CHAR_INIT, bkRgbDepth=BK_INIT, flashClk=1,
//   flash counter=0, outColor edge-history register=0. Reset mid-operation aborts everything.
// - Colour step: per bit i of outColor, a step fires on its rising edge (bit 1 now, 0 last
//   cycle); holding a bit high gives exactly one step. Step target = bkRgbDepth if enBkgrd==1
//   at that edge, else charRgbDepth. Channel += 1 modulo 2^CH_W (3'd7 -> 3'd0), other
//   channels and other target untouched. Result visible the cycle after the sampling edge.
// - Simultaneous edges on several bits: each selected channel steps independently same cycle.
// - enBkgrd toggling never changes stored colours; only routes later steps.
// - Flash, enFlash==0: counter held 0, flashClk=1 (registered, from next edge).
// - Flash, enFlash==1: counter counts 0..FLASH_DIV-1; on reaching FLASH_DIV-1 it wraps to 0
//   and flashClk inverts. First inversion FLASH_DIV cycles after enFlash rises; flashClk
//   period = 2*FLASH_DIV. Deasserting enFlash mid-period: counter->0, flashClk->1 next edge.
// - Counter width = $clog2(FLASH_DIV)+1; no overflow possible.
// - All outputs are registers; no combinational input->output paths.
// STRUCTURE
// - Shared package: CH_W, RGB word width, channel slice index constants (R/G/B offsets),
//   colour constants WHITE=9'h1FF, BLACK=9'h000.
// - One sub-module: flash_handler (clock, reset, enFlash, flashClk; param FLASH_DIV).
//   Colour registers and edge detect stay in the top level.
// TESTING (use FLASH_DIV=4)
// - Reset: drive reset=0 mid-run -> char=9'h1FF, bk=9'h000, flashClk=1 immediately.
// - enBkgrd=0, pulse outColor=3'b001 once from reset -> char=9'h03F (R 7->0 wrap), bk unchanged.
// - enBkgrd=1, outColor=3'b100 held 10 cycles -> bk=9'h001 (single step), char unchanged.
// - enBkgrd=1, outColor 3'b000->3'b011 -> bk R and G both +1 same cycle: 9'h000 -> 9'h048.
// - enFlash=1 -> flashClk 1 for 4 cycles, 0 for 4, 1 for 4...; drop enFlash while low ->
//   flashClk=1 next edge, stays 1.
// - G stepped 8 times on char -> returns to original value (modulo wrap check).

Source files
------------

// File: rtl/color_handler_pkg.sv
// Shared constants for the colour/flash back end: channel width, RGB word layout and
// the reset colours.
package color_handler_pkg;
    localparam int CH_W  = 3;
    localparam int RGB_W = 3 * CH_W;

    // Bit offset of each channel inside an RGB word {R,G,B}.
    localparam int R_OFF = 2 * CH_W;
    localparam int G_OFF = CH_W;
    localparam int B_OFF = 0;

    localparam logic [RGB_W-1:0] WHITE = 9'h1FF;
    localparam logic [RGB_W-1:0] BLACK = 9'h000;
endpackage

// File: rtl/color_handler_flash.sv
// Character blink strobe: while enabled, flashClk inverts every FLASH_DIV cycles;
// while disabled it is forced high so the character stays visible.
module flash_handler #(
    parameter int FLASH_DIV = 25000000
) (
    input  logic clock,
    input  logic reset,
    input  logic enFlash,
    output logic flashClk
);
    localparam int CNT_W = $clog2(FLASH_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flash_q, flash_d;

    always_comb begin
        cnt_d   = cnt_q;
        flash_d = flash_q;
        if (!enFlash) begin
            cnt_d   = '0;
            flash_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            flash_d = ~flash_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            flash_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            flash_q <= flash_d;
        end
    end

    assign flashClk = flash_q;
endmodule

// File: rtl/color_handler.sv
// Holds the character and background RGB colours, stepping one channel per rising edge
// of each outColor bit, and hosts the character blink strobe.
module color_handler
    import color_handler_pkg::*;
#(
    parameter int                  CH_W      = color_handler_pkg::CH_W,
    parameter logic [3*CH_W-1:0]   CHAR_INIT = color_handler_pkg::WHITE,
    parameter logic [3*CH_W-1:0]   BK_INIT   = color_handler_pkg::BLACK,
    parameter int                  FLASH_DIV = 25000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enBkgrd,
    input  logic [2:0]        outColor,
    input  logic              enFlash,
    output logic [3*CH_W-1:0] charRgbDepth,
    output logic [3*CH_W-1:0] bkRgbDepth,
    output logic              flashClk
);
    logic [3*CH_W-1:0] char_q, char_d;
    logic [3*CH_W-1:0] bk_q, bk_d;
    logic [2:0]        prev_q, prev_d;
    logic [2:0]        rise;

    assign rise   = outColor & ~prev_q;
    assign prev_d = outColor;

    // outColor bit i drives channel R/G/B, which sits (2-i) channels up from bit 0.
    always_comb begin
        char_d = char_q;
        bk_d   = bk_q;
        for (int i = 0; i < 3; i++) begin
            if (rise[i]) begin
                if (enBkgrd)
                    bk_d[(2-i)*CH_W +: CH_W] = bk_q[(2-i)*CH_W +: CH_W] + CH_W'(1);
                else
                    char_d[(2-i)*CH_W +: CH_W] = char_q[(2-i)*CH_W +: CH_W] + CH_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            char_q <= CHAR_INIT;
            bk_q   <= BK_INIT;
            prev_q <= 3'b000;
        end else begin
            char_q <= char_d;
            bk_q   <= bk_d;
            prev_q <= prev_d;
        end
    end

    assign charRgbDepth = char_q;
    assign bkRgbDepth   = bk_q;

    flash_handler #(
        .FLASH_DIV(FLASH_DIV)
    ) u_flash (
        .clock   (clock),
        .reset   (reset),
        .enFlash (enFlash),
        .flashClk(flashClk)
    );
endmodule

// File: tb/tb_color_handler.sv
// Directed bench for color_handler with a short blink period (FLASH_DIV = 4).
module tb_color_handler;
    logic       clock;
    logic       reset;
    logic       enBkgrd;
    logic [2:0] outColor;
    logic       enFlash;
    logic [8:0] charRgbDepth;
    logic [8:0] bkRgbDepth;
    logic       flashClk;

    int passed = 0;
    int total  = 0;

    color_handler #(
        .FLASH_DIV(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enBkgrd     (enBkgrd),
        .outColor    (outColor),
        .enFlash     (enFlash),
        .charRgbDepth(charRgbDepth),
        .bkRgbDepth  (bkRgbDepth),
        .flashClk    (flashClk)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge and settle; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        enBkgrd  = 1'b0;
        outColor = 3'b000;
        enFlash  = 1'b0;
        tick();
        tick();
        total++;
        if (charRgbDepth !== 9'h1FF)
            $display("FAIL reset_char: got %h expected %h", charRgbDepth, 9'h1FF);
        else passed++;
        total++;
        if (bkRgbDepth !== 9'h000)
            $display("FAIL reset_bk: got %h expected %h", bkRgbDepth, 9'h000);
        else passed++;
        total++;
        if (flashClk !== 1'b1)
            $display("FAIL reset_flash: got %b expected 1", flashClk);
        else passed++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_char_red_wrap();
        enBkgrd  = 1'b0;
        outColor = 3'b001;
        tick();
        outColor = 3'b000;
        total++;
        if (charRgbDepth !== 9'h03F)
            $display("FAIL char_red_wrap: got %h expected %h", charRgbDepth, 9'h03F);
        else passed++;
        tick();
        total++;
        if (charRgbDepth !== 9'h03F || bkRgbDepth !== 9'h000)
            $display("FAIL char_red_stable: got char %h bk %h expected 03f 000",
                     charRgbDepth, bkRgbDepth);
        else passed++;
    endtask

    task automatic test_bk_hold();
        enBkgrd  = 1'b1;
        outColor = 3'b100;
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (bkRgbDepth !== 9'h001)
            $display("FAIL bk_hold_single_step: got %h expected %h", bkRgbDepth, 9'h001);
        else passed++;
        total++;
        if (charRgbDepth !== 9'h03F)
            $display("FAIL bk_hold_char_untouched: got %h expected %h", charRgbDepth, 9'h03F);
        else passed++;
        outColor = 3'b000;
        tick();
        // Routing toggles alone must not disturb stored colours.
        enBkgrd = 1'b0;
        tick();
        enBkgrd = 1'b1;
        tick();
        total++;
        if (bkRgbDepth !== 9'h001 || charRgbDepth !== 9'h03F)
            $display("FAIL enbkgrd_toggle: got char %h bk %h expected 03f 001",
                     charRgbDepth, bkRgbDepth);
        else passed++;
    endtask

    task automatic test_bk_multi();
        do_reset();
        enBkgrd  = 1'b1;
        outColor = 3'b000;
        tick();
        outColor = 3'b011;
        tick();
        total++;
        if (bkRgbDepth !== 9'h048)
            $display("FAIL bk_multi_edge: got %h expected %h", bkRgbDepth, 9'h048);
        else passed++;
        total++;
        if (charRgbDepth !== 9'h1FF)
            $display("FAIL bk_multi_char: got %h expected %h", charRgbDepth, 9'h1FF);
        else passed++;
        outColor = 3'b000;
        tick();
    endtask

    task automatic test_g_wrap();
        enBkgrd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            outColor = 3'b010;
            tick();
            outColor = 3'b000;
            if (i == 0) begin
                total++;
                if (charRgbDepth !== 9'h1C7)
                    $display("FAIL g_first_step: got %h expected %h", charRgbDepth, 9'h1C7);
                else passed++;
            end
            tick();
        end
        total++;
        if (charRgbDepth !== 9'h1FF)
            $display("FAIL g_wrap_8_steps: got %h expected %h", charRgbDepth, 9'h1FF);
        else passed++;
        total++;
        if (bkRgbDepth !== 9'h048)
            $display("FAIL g_wrap_bk: got %h expected %h", bkRgbDepth, 9'h048);
        else passed++;
    endtask

    task automatic test_flash();
        logic exp_f;
        int   errs;
        errs    = 0;
        enFlash = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            exp_f = ((k / 4) % 2 == 0);
            total++;
            if (flashClk !== exp_f) begin
                $display("FAIL flash_cycle_%0d: got %b expected %b", k, flashClk, exp_f);
                errs++;
            end else passed++;
        end
        // flashClk is low here (cycle 13); dropping enFlash must restore it next edge.
        enFlash = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (flashClk !== 1'b1)
                $display("FAIL flash_disable_%0d: got %b expected 1", k, flashClk);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_run();
        enFlash  = 1'b1;
        enBkgrd  = 1'b0;
        outColor = 3'b100;
        tick();
        outColor = 3'b000;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (flashClk !== 1'b0 || charRgbDepth !== 9'h1F8)
            $display("FAIL pre_reset_state: got flash %b char %h expected 0 1f8",
                     flashClk, charRgbDepth);
        else passed++;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (charRgbDepth !== 9'h1FF || bkRgbDepth !== 9'h000 || flashClk !== 1'b1)
            $display("FAIL async_reset: got char %h bk %h flash %b expected 1ff 000 1",
                     charRgbDepth, bkRgbDepth, flashClk);
        else passed++;
        enFlash = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_char_red_wrap();
        test_bk_hold();
        test_bk_multi();
        test_g_wrap();
        test_flash();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
